// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: operand width, register index type, stack
// pointer location and status flag bit positions.
package cpu_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int FLAG_W = 8;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t         REG_SP = 3'd7;
    localparam logic [WIDTH-1:0] SP_RST = 16'hFFFF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

endpackage

// File: rtl/register_file.sv
// General-purpose register bank feeding the ALU: registered A/B operands,
// tri-state bus load/drive, stack pointer inc/dec and ALU status latch.
module register_file #(
    parameter int               WIDTH  = cpu_pkg::WIDTH,
    parameter int               NREGS  = cpu_pkg::NREGS,
    parameter int               SP_IDX = int'(cpu_pkg::REG_SP),
    parameter logic [WIDTH-1:0] SP_RST = cpu_pkg::SP_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             we,
    input  logic [2:0]       wsel,
    input  logic             oe,
    input  logic [2:0]       osel,
    input  logic [2:0]       asel,
    input  logic [2:0]       bsel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             sp_inc,
    input  logic             sp_dec,
    output logic [WIDTH-1:0] sp,
    input  logic [7:0]       f_in,
    input  logic             f_ld,
    output logic [7:0]       flags
);

    import cpu_pkg::*;

    // Every select value has a slot; slots at or above NREGS stay at zero.
    localparam int NSLOT = 8;

    // No handshake: the control unit sequences everything, and each control
    // input takes effect on the posedge of the cycle it is asserted.

    logic [WIDTH-1:0] regs [NSLOT];
    logic [WIDTH-1:0] nxt  [NSLOT];
    logic [WIDTH-1:0] rd;

    function automatic logic [WIDTH-1:0] reg_next(
        input int               idx,
        input logic [WIDTH-1:0] cur,
        input logic             wr,
        input logic [2:0]       wr_sel,
        input logic [WIDTH-1:0] wr_data,
        input logic             inc,
        input logic             dec
    );
        if (idx >= NREGS)
            return '0;
        if (wr && int'(wr_sel) == idx)
            return wr_data;
        if (idx == SP_IDX && (inc ^ dec))
            return inc ? cur + WIDTH'(1) : cur - WIDTH'(1);
        return cur;
    endfunction

    for (genvar i = 0; i < NSLOT; i++) begin : g_reg
        localparam logic [WIDTH-1:0] RST_VAL = (i == SP_IDX) ? SP_RST : '0;
        logic [WIDTH-1:0] q;

        assign nxt[i] = reg_next(i, q, we, wsel, bus, sp_inc, sp_dec);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= RST_VAL;
            else
                q <= nxt[i];
        end

        assign regs[i] = q;
    end

    assign rd  = regs[osel];
    assign bus = oe ? rd : {WIDTH{1'bz}};
    assign sp  = regs[SP_IDX];

    // Operands sample the post-update array so a write is visible next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else begin
            a <= nxt[asel];
            b <= nxt[bsel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= '0;
        else if (f_ld)
            flags <= f_in;
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, bus load/drive, moves, stack
// pointer wrap and priority, flag latch, bus release and back-to-back writes.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    wire  [15:0] bus;
    logic        drv_en;
    logic [15:0] drv_val;
    logic        we, oe, sp_inc, sp_dec, f_ld;
    logic [2:0]  wsel, osel, asel, bsel;
    logic [15:0] a, b, sp;
    logic [7:0]  f_in, flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign bus = drv_en ? drv_val : 16'hzzzz;

    register_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .we     (we),
        .wsel   (wsel),
        .oe     (oe),
        .osel   (osel),
        .asel   (asel),
        .bsel   (bsel),
        .a      (a),
        .b      (b),
        .sp_inc (sp_inc),
        .sp_dec (sp_dec),
        .sp     (sp),
        .f_in   (f_in),
        .f_ld   (f_ld),
        .flags  (flags)
    );

    task automatic idle();
        drv_en  = 1'b0;
        drv_val = 16'h0000;
        we      = 1'b0;
        oe      = 1'b0;
        sp_inc  = 1'b0;
        sp_dec  = 1'b0;
        f_ld    = 1'b0;
        f_in    = 8'h00;
        wsel    = 3'd0;
        osel    = 3'd0;
        asel    = 3'd0;
        bsel    = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        drv_en = 1'b1; drv_val = 16'hBEEF; we = 1'b1; wsel = 3'd0;
        asel = 3'd0; bsel = 3'd7; f_in = 8'hFF; f_ld = 1'b1;
        tick();
        checks++;
        if (a !== 16'hBEEF) begin
            errors++; $display("FAIL pre_reset_a got %h want %h", a, 16'hBEEF);
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a !== 16'h0000) begin errors++; $display("FAIL reset_a got %h want 0000", a); end
        checks++;
        if (b !== 16'h0000) begin errors++; $display("FAIL reset_b got %h want 0000", b); end
        checks++;
        if (sp !== 16'hFFFF) begin errors++; $display("FAIL reset_sp got %h want FFFF", sp); end
        checks++;
        if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h want 00", flags); end
        oe = 1'b1; osel = 3'd0;
        #1;
        checks++;
        if (bus !== 16'h0000) begin errors++; $display("FAIL reset_reg0 got %h want 0000", bus); end
        oe = 1'b0; drv_en = 1'b1; drv_val = 16'h3C3C;
        #1;
        checks++;
        if (bus !== 16'h3C3C) begin errors++; $display("FAIL reset_bus_release got %h want 3C3C", bus); end
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 8; i++) begin
            oe = 1'b1; osel = 3'(i);
            #1;
            checks++;
            if (bus !== ((i == 7) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL reset_reg%0d got %h want %h", i, bus, (i == 7) ? 16'hFFFF : 16'h0000);
            end
        end
        idle();
    endtask

    task automatic test_load();
        idle();
        drv_en = 1'b1; drv_val = 16'h1234; we = 1'b1; wsel = 3'd2; asel = 3'd2;
        tick();
        checks++;
        if (a !== 16'h1234) begin errors++; $display("FAIL load_a got %h want 1234", a); end
        idle();
        oe = 1'b1; osel = 3'd2; asel = 3'd2;
        #1;
        checks++;
        if (bus !== 16'h1234) begin errors++; $display("FAIL load_bus got %h want 1234", bus); end
        idle();
    endtask

    task automatic test_move();
        idle();
        drv_en = 1'b1; drv_val = 16'h00AA; we = 1'b1; wsel = 3'd1;
        tick();
        idle();
        oe = 1'b1; osel = 3'd1; we = 1'b1; wsel = 3'd3; bsel = 3'd3;
        tick();
        checks++;
        if (b !== 16'h00AA) begin errors++; $display("FAIL move_b got %h want 00AA", b); end
        idle();
        oe = 1'b1; osel = 3'd3;
        #1;
        checks++;
        if (bus !== 16'h00AA) begin errors++; $display("FAIL move_reg3 got %h want 00AA", bus); end
        idle();
    endtask

    task automatic test_sp();
        idle();
        checks++;
        if (sp !== 16'hFFFF) begin errors++; $display("FAIL sp_start got %h want FFFF", sp); end
        sp_inc = 1'b1;
        tick();
        checks++;
        if (sp !== 16'h0000) begin errors++; $display("FAIL sp_inc_wrap got %h want 0000", sp); end
        sp_inc = 1'b0; sp_dec = 1'b1;
        tick();
        checks++;
        if (sp !== 16'hFFFF) begin errors++; $display("FAIL sp_dec_wrap got %h want FFFF", sp); end
        sp_inc = 1'b1; sp_dec = 1'b1;
        tick();
        checks++;
        if (sp !== 16'hFFFF) begin errors++; $display("FAIL sp_both_hold got %h want FFFF", sp); end
        idle();
        drv_en = 1'b1; drv_val = 16'h8000; we = 1'b1; wsel = 3'd7; sp_inc = 1'b1; asel = 3'd7;
        tick();
        checks++;
        if (sp !== 16'h8000) begin errors++; $display("FAIL sp_write_prio got %h want 8000", sp); end
        checks++;
        if (a !== 16'h8000) begin errors++; $display("FAIL sp_write_a got %h want 8000", a); end
        idle();
        sp_dec = 1'b1; bsel = 3'd7;
        tick();
        checks++;
        if (sp !== 16'h7FFF) begin errors++; $display("FAIL sp_dec got %h want 7FFF", sp); end
        checks++;
        if (b !== 16'h7FFF) begin errors++; $display("FAIL sp_dec_b got %h want 7FFF", b); end
        idle();
    endtask

    task automatic test_flags();
        idle();
        f_in = 8'h02; f_ld = 1'b1;
        tick();
        checks++;
        if (flags !== 8'h02) begin errors++; $display("FAIL flags_load got %h want 02", flags); end
        f_in = 8'h01; f_ld = 1'b0; we = 1'b1; wsel = 3'd5; drv_en = 1'b1; drv_val = 16'h0000;
        tick();
        checks++;
        if (flags !== 8'h02) begin errors++; $display("FAIL flags_hold got %h want 02", flags); end
        idle();
        f_in = 8'h01; f_ld = 1'b1;
        tick();
        checks++;
        if (flags !== 8'h01) begin errors++; $display("FAIL flags_reload got %h want 01", flags); end
        idle();
    endtask

    task automatic test_bus_release();
        logic [15:0] v;
        idle();
        for (int i = 0; i < 10; i++) begin
            v = 16'($urandom_range(0, 255));
            drv_en = 1'b1; drv_val = v; oe = 1'b0; osel = 3'd2;
            asel = 3'($urandom_range(0, 7)); bsel = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (bus !== v) begin errors++; $display("FAIL bus_release_%0d got %h want %h", i, bus, v); end
        end
        idle();
        drv_en = 1'b1; drv_val = 16'h5555; we = 1'b1; wsel = 3'd4; asel = 3'd4;
        tick();
        checks++;
        if (a !== 16'h5555) begin errors++; $display("FAIL alu_load_a got %h want 5555", a); end
        idle();
        oe = 1'b1; osel = 3'd4;
        #1;
        checks++;
        if (bus !== 16'h5555) begin errors++; $display("FAIL alu_load_reg4 got %h want 5555", bus); end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        drv_en = 1'b1; drv_val = 16'h0F0F; we = 1'b1; wsel = 3'd5;
        tick();
        drv_val = 16'hF0F0; wsel = 3'd6; asel = 3'd5; bsel = 3'd6;
        tick();
        checks++;
        if (a !== 16'h0F0F) begin errors++; $display("FAIL b2b_a got %h want 0F0F", a); end
        checks++;
        if (b !== 16'hF0F0) begin errors++; $display("FAIL b2b_b got %h want F0F0", b); end
        idle();
        asel = 3'd5; bsel = 3'd5;
        tick();
        checks++;
        if (a !== 16'h0F0F || b !== 16'h0F0F) begin
            errors++; $display("FAIL same_sel got a=%h b=%h want 0F0F", a, b);
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_load();
        test_move();
        test_sp();
        test_flags();
        test_bus_release();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
